// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: FSM states,
// opcodes, ALU operation codes and immediate-format selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Codes are held at 4 bits; narrower ALUs take the low bits.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU decoder: maps ALUOp/funct3/funct7b5 to an ALU code and flags
// operations that have no code at the configured ALUControl width.
module mc_alu_dec
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic [1:0]           i_alu_op,
    input  logic [6:0]           i_op,
    input  logic [2:0]           i_funct3,
    input  logic                 i_funct7b5,
    output logic [ALUCTRL_W-1:0] o_alu_control,
    output logic                 o_alu_illegal
);

    logic [3:0] w_funct_code;
    logic [3:0] w_code;
    logic       w_wide_only;

    always_comb begin
        w_funct_code = ALU_ADD;
        w_wide_only  = 1'b0;
        case (i_funct3)
            3'b000: w_funct_code = (i_op[5] && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: w_funct_code = ALU_SLL;
            3'b010: w_funct_code = ALU_SLT;
            3'b011: begin
                w_funct_code = ALU_SLTU;
                w_wide_only  = 1'b1;
            end
            3'b100: w_funct_code = ALU_XOR;
            3'b101: begin
                w_funct_code = i_funct7b5 ? ALU_SRA : ALU_SRL;
                w_wide_only  = i_funct7b5;
            end
            3'b110: w_funct_code = ALU_OR;
            default: w_funct_code = ALU_AND;
        endcase
    end

    always_comb begin
        case (i_alu_op)
            ALUOP_SUB:   w_code = ALU_SUB;
            ALUOP_FUNCT: w_code = w_funct_code;
            default:     w_code = ALU_ADD;
        endcase
    end

    // Legality depends only on the funct fields so DECODE can test it
    // before the execute state drives ALUOp.
    assign o_alu_illegal = (ALUCTRL_W < 4) && w_wide_only;
    assign o_alu_control = w_code[ALUCTRL_W-1:0];

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I control FSM with memory wait states, run gate and a
// sticky illegal-instruction trap. CTRL_RETIRE_CNT_EN enables instret.
module mc_controller
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W  = 3,
    parameter int BRANCH_SET = 0,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    input  logic                 Lt,
    input  logic                 Ltu,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Illegal,
    output logic [CNT_W-1:0]     instret
);

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    logic [1:0] w_alu_op;
    logic       w_alu_illegal;
    logic       w_branch_ok;
    logic       w_branch;
    logic       w_taken;
    logic       w_pc_update;

    mc_alu_dec #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_op          (op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .o_alu_control (ALUControl),
        .o_alu_illegal (w_alu_illegal)
    );

    assign w_branch_ok = (BRANCH_SET == 0) ? (funct3 == 3'b000) : (funct3[2:1] != 2'b01);

    always_comb begin
        case (funct3)
            3'b000:  w_taken = Zero;
            3'b001:  w_taken = !Zero;
            3'b100:  w_taken = Lt;
            3'b101:  w_taken = !Lt;
            3'b110:  w_taken = Ltu;
            3'b111:  w_taken = !Ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (run && MemReady) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:  w_next = w_alu_illegal ? S_TRAP : S_EXECR;
                    OP_ITYPE:  w_next = w_alu_illegal ? S_TRAP : S_EXECI;
                    OP_BRANCH: w_next = w_branch_ok ? S_BRANCH : S_TRAP;
                    OP_JAL:    w_next = S_JAL;
                    default:   w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (MemReady) w_next = S_FETCH;
            S_EXECR,
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | (w_next == S_TRAP);
        end
    end

    // Strobes are gated by reset so an aborted store drops MemWrite at once.
    always_comb begin
        AdrSrc      = 1'b0;
        IRWrite     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        w_alu_op    = ALUOP_ADD;
        w_branch    = 1'b0;
        w_pc_update = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    if (run) begin
                        ALUSrcB     = 2'b10;
                        ResultSrc   = 2'b10;
                        IRWrite     = MemReady;
                        w_pc_update = MemReady;
                    end
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD:  AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR, S_EXECI: begin
                    ALUSrcA  = 2'b10;
                    ALUSrcB  = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                    w_alu_op = ALUOP_FUNCT;
                end
                S_ALUWB:    RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA  = 2'b10;
                    w_alu_op = ALUOP_SUB;
                    w_branch = 1'b1;
                end
                S_JAL: begin
                    ALUSrcA     = 2'b01;
                    ALUSrcB     = 2'b10;
                    w_pc_update = 1'b1;
                end
                default: ;
            endcase
        end
        PCWrite = w_pc_update | (w_branch & w_taken);
    end

    assign ImmSrc  = imm_src(op);
    assign Illegal = r_illegal;

`ifdef CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_instret;
    logic             w_retire;

    // JAL retires on its ALUWB exit; TRAP never returns to FETCH.
    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BRANCH)
                   || ((r_state == S_MEMWRITE) && MemReady);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 1'b1;
        end
    end

    assign instret = r_instret;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: a wide/all-branch instance and a default instance
// run in lockstep against an instruction-level schedule model.
module tb_mc_controller;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset, run, funct7b5, Zero, Lt, Ltu, MemReady;
    logic [6:0] op;
    logic [2:0] funct3;

    logic        pcw_a, adr_a, irw_a, memw_a, regw_a, ill_a;
    logic [1:0]  rs_a, sa_a, sb_a, imm_a;
    logic [3:0]  alu_a;
    logic [31:0] cnt_a;
    logic        pcw_b, adr_b, irw_b, memw_b, regw_b, ill_b;
    logic [1:0]  rs_b, sa_b, sb_b, imm_b;
    logic [2:0]  alu_b;
    logic [31:0] cnt_b;

    mc_controller #(.ALUCTRL_W(4), .BRANCH_SET(1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .run(run), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .MemReady(MemReady),
        .PCWrite(pcw_a), .AdrSrc(adr_a), .IRWrite(irw_a), .MemWrite(memw_a), .RegWrite(regw_a),
        .ResultSrc(rs_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ImmSrc(imm_a),
        .ALUControl(alu_a), .Illegal(ill_a), .instret(cnt_a)
    );

    mc_controller #(.ALUCTRL_W(3), .BRANCH_SET(0), .CNT_W(32)) dut_b (
        .clk(clk), .reset(reset), .run(run), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .MemReady(MemReady),
        .PCWrite(pcw_b), .AdrSrc(adr_b), .IRWrite(irw_b), .MemWrite(memw_b), .RegWrite(regw_b),
        .ResultSrc(rs_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ImmSrc(imm_b),
        .ALUControl(alu_b), .Illegal(ill_b), .instret(cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       irw, pcw, regw, memw, adr;
        logic [1:0] rs, sa, sb, imm;
        logic [3:0] alu;
        logic       ill;
    } rec_t;

    int checks   = 0;
    int failures = 0;
    int unsigned cnt_model = 0;

    rec_t qa[$];
    rec_t qb[$];
    int   mrq[$];

    function automatic rec_t obs_a();
        return {irw_a, pcw_a, regw_a, memw_a, adr_a, rs_a, sa_a, sb_a, imm_a, alu_a, ill_a};
    endfunction

    function automatic rec_t obs_b();
        return {irw_b, pcw_b, regw_b, memw_b, adr_b, rs_b, sa_b, sb_b, imm_b, 1'b0, alu_b, ill_b};
    endfunction

    function automatic rec_t mk(logic irw, logic pcw, logic regw, logic memw, logic adr,
                                logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                logic [3:0] alu, logic ill, logic [1:0] imm);
        return {irw, pcw, regw, memw, adr, rs, sa, sb, imm, alu, ill};
    endfunction

    function automatic logic [1:0] exp_imm(logic [6:0] o);
        if (o == OP_STORE)  return 2'b01;
        if (o == OP_BRANCH) return 2'b10;
        if (o == OP_JAL)    return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [3:0] exp_alu(logic [6:0] o, logic [2:0] f3, logic f7);
        case (f3)
            3'd0: return (o[5] && f7) ? 4'b0001 : 4'b0000;
            3'd1: return 4'b0110;
            3'd2: return 4'b0101;
            3'd3: return 4'b1001;
            3'd4: return 4'b0100;
            3'd5: return f7 ? 4'b1000 : 4'b0111;
            3'd6: return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic exp_taken(logic [2:0] f3, logic z, logic l, logic lu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            3'd7: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef CTRL_RETIRE_CNT_EN
        return cnt_model;
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk_rec(string tag, rec_t obs, rec_t expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk32(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        cnt_model = 0;
    endtask

    // One instruction: fw fetch wait cycles, mw memory wait cycles; abort_at
    // asserts reset right after that cycle index is checked.
    task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input logic l, input logic lu,
                            input int fw, input int mw, input int abort_at);
        logic [1:0] im;
        logic       is_alu, known, legal_a, legal_b;
        rec_t       trap_r, wait_r;
        im      = exp_imm(o);
        is_alu  = (o == OP_RTYPE) || (o == OP_ITYPE);
        known   = (o == OP_LOAD) || (o == OP_STORE) || is_alu || (o == OP_BRANCH) || (o == OP_JAL);
        legal_a = known && !(o == OP_BRANCH && f3[2:1] == 2'b01);
        legal_b = legal_a && !(o == OP_BRANCH && f3 != 3'd0)
                  && !(is_alu && (f3 == 3'd3 || (f3 == 3'd5 && f7)));
        trap_r  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 1, im);
        wait_r  = mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'd0, 0, im);
        qa.delete(); qb.delete(); mrq.delete();
        for (int i = 0; i < fw; i++) begin qa.push_back(wait_r); mrq.push_back(0); end
        qa.push_back(mk(1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'd0, 0, im)); mrq.push_back(1);
        qa.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'd0, 0, im)); mrq.push_back(2);
        if (!legal_a) begin
            qa.push_back(trap_r); mrq.push_back(2);
        end else if (o == OP_LOAD || o == OP_STORE) begin
            qa.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 0, im)); mrq.push_back(2);
            for (int i = 0; i <= mw; i++) begin
                qa.push_back(mk(0, 0, 0, o[5], 1, 2'b00, 2'b00, 2'b00, 4'd0, 0, im));
                mrq.push_back(i == mw ? 1 : 0);
            end
            if (!o[5]) begin
                qa.push_back(mk(0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 4'd0, 0, im)); mrq.push_back(2);
            end
        end else if (is_alu) begin
            qa.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == OP_ITYPE) ? 2'b01 : 2'b00,
                            exp_alu(o, f3, f7), 0, im)); mrq.push_back(2);
            qa.push_back(mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, im)); mrq.push_back(2);
        end else if (o == OP_BRANCH) begin
            qa.push_back(mk(0, exp_taken(f3, z, l, lu), 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'b0001, 0, im));
            mrq.push_back(2);
        end else begin
            qa.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'd0, 0, im)); mrq.push_back(2);
            qa.push_back(mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, im)); mrq.push_back(2);
        end
        for (int i = 0; i < qa.size(); i++) qb.push_back((legal_b || i < fw + 2) ? qa[i] : trap_r);

        for (int i = 0; i < qa.size(); i++) begin
            @(negedge clk);
            run = 1'b1; op = o; funct3 = f3; funct7b5 = f7; Zero = z; Lt = l; Ltu = lu;
            MemReady = (mrq[i] == 2) ? 1'($urandom_range(0, 1)) : mrq[i][0];
            #1;
            chk_rec($sformatf("a op=%b f3=%0d cyc=%0d", o, f3, i), obs_a(), qa[i]);
            chk_rec($sformatf("b op=%b f3=%0d cyc=%0d", o, f3, i), obs_b(), qb[i]);
            $display("step op=%b f3=%0d f7=%0d cyc=%0d MemReady=%0d", o, f3, f7, i, MemReady);
            if (i == abort_at) begin
                #1 reset = 1'b1;
                #1;
                chk_rec("reset_mid_a", obs_a(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, im));
                chk_rec("reset_mid_b", obs_b(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, im));
                reset = 1'b0; MemReady = 1'b0; cnt_model = 0;
                #1;
                chk_rec("after_reset_fetch_a", obs_a(), wait_r);
                chk_rec("after_reset_fetch_b", obs_b(), wait_r);
                return;
            end
        end

        if (legal_a && legal_b) begin
            @(posedge clk); #1;
            cnt_model++;
            chk32("instret_a", cnt_a, exp_cnt());
            chk32("instret_b", cnt_b, exp_cnt());
        end else begin
            run = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk); #1;
                chk32("sticky_ill_a", 32'(ill_a), 32'(!legal_a));
                chk32("sticky_ill_b", 32'(ill_b), 32'(1));
            end
            pulse_reset();
            chk32("ill_cleared_b", 32'(ill_b), 32'(0));
            chk32("instret_cleared_a", cnt_a, 32'd0);
        end
    endtask

    initial begin
        logic [6:0] ops [8];
        ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_BRANCH, OP_JAL, 7'b0110111};
        reset = 1'b1; run = 1'b0; MemReady = 1'b0; op = OP_RTYPE; funct3 = 3'd0;
        funct7b5 = 1'b0; Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
        #1;
        chk_rec("reset_a", obs_a(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 2'b00));
        chk_rec("reset_b", obs_b(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 2'b00));
        chk32("reset_instret_a", cnt_a, 32'd0);
        #3 reset = 1'b0;

        do_instr(OP_LOAD,   3'd2, 0, 0, 0, 0, 0, 3, -1);   // lw, 3 wait cycles
        do_instr(OP_STORE,  3'd2, 0, 0, 0, 0, 0, 0, -1);   // sw, no wait
        do_instr(OP_BRANCH, 3'd1, 0, 0, 0, 0, 0, 0, -1);   // bne taken / trap on beq-only
        do_instr(OP_RTYPE,  3'd5, 1, 0, 0, 0, 0, 0, -1);   // sra / trap on 3-bit ALU

        @(negedge clk);
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            MemReady = 1'($urandom_range(0, 1));
            #1;
            chk_rec("idle_a", obs_a(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, exp_imm(op)));
            chk_rec("idle_b", obs_b(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, exp_imm(op)));
            $display("idle cyc=%0d MemReady=%0d", k, MemReady);
            @(negedge clk);
        end

        do_instr(OP_STORE, 3'd2, 0, 0, 0, 0, 1, 5, 4);     // reset during MEMWRITE

        do_instr(OP_RTYPE,  3'd0, 0, 0, 0, 0, 0, 0, -1);
        do_instr(OP_JAL,    3'd0, 0, 0, 0, 0, 1, 0, -1);
        do_instr(OP_BRANCH, 3'd0, 0, 0, 1, 1, 0, 0, -1);
        do_instr(OP_LOAD,   3'd2, 0, 0, 0, 0, 0, 1, -1);
`ifdef CTRL_RETIRE_CNT_EN
        chk32("retire_four", cnt_a, 32'd4);
`else
        chk32("retire_off", cnt_a, 32'd0);
`endif

        for (int n = 0; n < 40; n++) begin
            do_instr(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle RV32I control FSM; successor to the single-cycle controller.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Adds a memory wait-state handshake, a run gate, selectable branch coverage and ALU-code width, and a sticky illegal-instruction trap.
- Sits beside the multi-cycle datapath and drives its mux selects and write strobes.

Parameters:
- ALUCTRL_W, 3, ALUControl width. 3 = add/sub/and/or/xor/slt/sll/srl; 4 also adds sra (1000) and sltu (1001).
- BRANCH_SET, 0, branch coverage. 0 = beq only; 1 = all six RV32I branches.
- CNT_W, 32, retired-instruction counter width (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  start gate; sampled only in FETCH
- op  in  7  instruction opcode
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero, Lt, Ltu  in  1 each  ALU subtract flags
- MemReady  in  1  memory access complete this cycle
- PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  out  1 each  datapath strobes/selects
- ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  mux selects
- ALUControl  out  ALUCTRL_W  ALU operation code
- Illegal  out  1  sticky trap flag
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async): state=FETCH, Illegal=0, instret=0. Outputs are a pure function of state, inputs and registers, so all strobes are 0 while reset is held.
- State changes on posedge clk. Strobes are decoded combinationally from the state register.
- Default for every output is 0 unless listed below.
- PCWrite = PCUpdate | (Branch & taken).
- FETCH:
  - If run=0: no strobes, hold.
  - Otherwise AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALU add.
  - IRWrite=PCUpdate=MemReady; hold until MemReady, then DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target). Next state:
  - loads/stores (0000011/0100011) -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else, or an unsupported funct3 or ALU op -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next is MEMWRITE if op[5]=1, else MEMREAD.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held high until MemReady, then FETCH.
- EXECR (ALUSrcB=00) / EXECI (ALUSrcB=01): ALUSrcA=10, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Branch=1, then FETCH.
  - beq: taken=Zero; bne: !Zero; blt: Lt; bge: !Lt; bltu: Ltu; bgeu: !Ltu.
  - BRANCH_SET=0: any funct3 other than 000 traps at DECODE. funct3 010/011 always trap.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1, then ALUWB.
- TRAP: Illegal=1 and all strobes 0; absorbing until reset.
- ImmSrc from op, held in every state: 0010011/0000011 -> 00; 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; else 00.
- ALU decode:
  - ALUOp 00 -> add 000; 01 -> sub 001.
  - ALUOp 10, by funct3:
    - 000: sub if op[5]&funct7b5, else add
    - 001: sll 110
    - 010: slt 101
    - 011: sltu
    - 100: xor 100
    - 101: srl 111, or sra
    - 110: or 011
    - 111: and 010
  - With ALUCTRL_W=3, sltu and sra have no code and trap.
  - With ALUCTRL_W=4, all codes are zero-extended.
- Reset mid-access drops MemWrite the same instant.
- MemReady is ignored outside FETCH, MEMREAD and MEMWRITE.
- run is ignored outside FETCH: the current instruction always completes.

Optional Feature:
- Macro: CTRL_RETIRE_CNT_EN.
- Defined: instret increments, wrapping at 2^CNT_W, on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. JAL counts on its ALUWB exit. TRAP never counts.
- Undefined: instret is tied to 0 and no counter flops are synthesised.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum
  - opcode localparams (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL)
  - ALU code and ImmSrc constants
- One sub-module, mc_alu_dec: combinational ALUOp/funct decode producing ALUControl plus an alu_illegal flag consumed by DECODE.

Test Plan:
- lw x1, MemReady low 3 cycles in MEMREAD -> FETCH, DECODE, MEMADR, MEMREAD x4, MEMWB; RegWrite=1 only in MEMWB; 8 cycles total.
- sw, MemReady=1 -> MemWrite=1 for exactly 1 cycle in MEMWRITE with AdrSrc=1; 4 cycles.
- bne with Zero=0, BRANCH_SET=1 -> PCWrite=1 in BRANCH. With BRANCH_SET=0, same instruction -> TRAP, Illegal=1 stays high until reset.
- sra (funct3=101, funct7b5=1): ALUCTRL_W=4 -> ALUControl=1000 in EXECR. ALUCTRL_W=3 -> TRAP.
- run=0 held 5 cycles in FETCH -> all strobes 0. Assert reset during MEMWRITE -> MemWrite falls without a clock edge and state=FETCH.
- CTRL_RETIRE_CNT_EN defined: add, jal, beq(not taken), lw -> instret=4. Undefined -> instret=0.
